robertson_host: RTL

Host-side sequencer for the Robertson signed multiplier. It accepts a pair of signed 8-bit operands over a valid/ready request channel and drives the multiplier's `enable`/`inbus` load protocol. It then collects the 16-bit product from the two-beat `done`/`outbus` readout and returns it on a valid/ready response channel. It sits between a system-side client and one `robertson_top` instance, and owns the multiplier for the whole transaction.

---
 rtl/robertson_pkg.sv | 19 +
 rtl/robertson_host.sv | 107 ++++++++++
 2 files changed

// File: rtl/robertson_pkg.sv
// Shared types and widths for the Robertson multiplier host sequencer.
package robertson_pkg;

    localparam int OP_W      = 8;
    localparam int PROD_W    = 16;
    localparam int MUL_IN_W  = 8;
    localparam int MUL_OUT_W = 8;
    localparam int TMO_W     = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD_M    = 3'd1,
        ST_HOLD_M    = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_READ_LO   = 3'd4,
        ST_RESP      = 3'd5
    } host_state_t;

endpackage

// File: rtl/robertson_host.sv
// Host-side sequencer: loads M then Q into a robertson_top, collects the
// two-beat product readout and returns it on a valid/ready response channel.
module robertson_host
    import robertson_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [OP_W-1:0]      req_m,
    input  logic [OP_W-1:0]      req_q,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [PROD_W-1:0]    rsp_product,
    output logic                 rsp_timeout,
    output logic                 mul_enable,
    output logic [MUL_IN_W-1:0]  mul_inbus,
    input  logic                 mul_done,
    input  logic [MUL_OUT_W-1:0] mul_outbus
);

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    host_state_t      state_reg;
    logic [OP_W-1:0]  m_reg;
    logic [OP_W-1:0]  q_reg;
    logic [TMO_W-1:0] cnt_reg;

    // All outputs are registered and updated on the transition into the
    // state that owns them, so they are glitch-free at the ports.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            m_reg       <= '0;
            q_reg       <= '0;
            cnt_reg     <= '0;
            req_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_product <= '0;
            rsp_timeout <= 1'b0;
            mul_enable  <= 1'b0;
            mul_inbus   <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (req_valid) begin
                        m_reg       <= req_m;
                        q_reg       <= req_q;
                        cnt_reg     <= '0;
                        rsp_product <= '0;
                        rsp_timeout <= 1'b0;
                        req_ready   <= 1'b0;
                        mul_enable  <= 1'b1;
                        mul_inbus   <= req_m;
                        state_reg   <= ST_LOAD_M;
                    end
                end
                ST_LOAD_M: begin
                    mul_enable <= 1'b0;
                    mul_inbus  <= m_reg;
                    state_reg  <= ST_HOLD_M;
                end
                ST_HOLD_M: begin
                    mul_inbus <= q_reg;
                    state_reg <= ST_WAIT_DONE;
                end
                ST_WAIT_DONE: begin
                    cnt_reg <= cnt_reg + 1'b1;
                    // done takes priority over a timeout landing in the same cycle
                    if (mul_done) begin
                        rsp_product[PROD_W-1:MUL_OUT_W] <= mul_outbus;
                        state_reg <= ST_READ_LO;
                    end else if (cnt_reg == TMO_LAST) begin
                        rsp_timeout <= 1'b1;
                        rsp_product <= '0;
                        rsp_valid   <= 1'b1;
                        mul_inbus   <= '0;
                        state_reg   <= ST_RESP;
                    end
                end
                ST_READ_LO: begin
                    rsp_product[MUL_OUT_W-1:0] <= mul_outbus;
                    rsp_valid <= 1'b1;
                    mul_inbus <= '0;
                    state_reg <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state_reg <= ST_IDLE;
                    end
                end
                default: begin
                    rsp_valid  <= 1'b0;
                    req_ready  <= 1'b1;
                    mul_enable <= 1'b0;
                    mul_inbus  <= '0;
                    state_reg  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
